// File: rtl/jtag_pkg.sv
// Shared opcodes, FSM state encodings and TMS header patterns for the JTAG master.
package jtag_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'd0,
        OP_SHIFT_IR  = 2'd1,
        OP_SHIFT_DR  = 2'd2,
        OP_RUN_IDLE  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_TRAILER = 3'd4,
        ST_RUN     = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam int MAX_LEN = 32;

    // TMS value for header TCK number idx, starting from Run-Test/Idle.
    function automatic logic hdr_tms(input op_e op, input logic [5:0] idx);
        case (op)
            OP_TAP_RESET: hdr_tms = (idx != 6'd5);
            OP_SHIFT_IR:  hdr_tms = (idx < 6'd2);
            OP_SHIFT_DR:  hdr_tms = (idx == 6'd0);
            default:      hdr_tms = 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] hdr_last(input op_e op);
        case (op)
            OP_TAP_RESET: hdr_last = 6'd5;
            OP_SHIFT_IR:  hdr_last = 6'd3;
            OP_SHIFT_DR:  hdr_last = 6'd2;
            default:      hdr_last = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV clk cycles low then CLK_DIV high, with strobes on the
// clk edge where tck rises or falls. Held low and cleared while disabled.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    logic [7:0] cnt_q;
    logic       tck_q;
    logic       term;

    assign term = (cnt_q == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            tck_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= 8'd0;
            tck_q <= 1'b0;
        end else if (term) begin
            cnt_q <= 8'd0;
            tck_q <= ~tck_q;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign tck_o  = tck_q;
    assign rise_o = en_i & term & ~tck_q;
    assign fall_o = en_i & term & tck_q;

endmodule

// File: rtl/jtag_master.sv
// Command-driven JTAG master: TAP init after reset, then IR/DR shifts,
// TAP reset and Run-Test/Idle clocking, one response per command.
//
// state   | meaning
// INIT    | trst on first TCK, tms 1,1,1,1,1,0 to park TAP in Run-Test/Idle
// IDLE    | cmd_ready, waiting for a command
// HEADER  | tms walk from Run-Test/Idle into Shift-xR (or full TAP reset)
// SHIFT   | len data bits, tms=1 on the last
// TRAILER | tms 1,0 back to Run-Test/Idle
// RUN     | len TCKs with tms=0
// DONE    | rejected command, error response in flight
module jtag_master
    import jtag_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    output logic        trst,
    input  logic        tdo
);

    state_e      state_q;
    op_e         op_q;
    logic [5:0]  len_q, cnt_q, cnt_inc, len_m1;
    logic [31:0] data_q, cap_q, rsp_data_q;
    logic        tms_q, tdi_q, trst_q, cmd_ready_q, rsp_valid_q, rsp_err_q;
    logic        tck_en, tck_rise, tck_fall;

    assign cnt_inc = cnt_q + 6'd1;
    assign len_m1  = len_q - 6'd1;
    assign tck_en  = (state_q != ST_IDLE) && (state_q != ST_DONE);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (tck_en),
        .tck_o  (tck),
        .rise_o (tck_rise),
        .fall_o (tck_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            op_q        <= OP_TAP_RESET;
            len_q       <= 6'd0;
            cnt_q       <= 6'd0;
            data_q      <= 32'd0;
            cap_q       <= 32'd0;
            rsp_data_q  <= 32'd0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                ST_INIT: if (tck_fall) begin
                    trst_q <= 1'b0;
                    if (cnt_q == hdr_last(OP_TAP_RESET)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 6'd0;
                        tms_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                        tms_q <= hdr_tms(OP_TAP_RESET, cnt_inc);
                    end
                end
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= op_e'(cmd_op);
                        len_q       <= cmd_len;
                        data_q      <= cmd_data;
                        cap_q       <= 32'd0;
                        cnt_q       <= 6'd0;
                        if (cmd_len == 6'd0 || cmd_len > 6'(MAX_LEN)) begin
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= 32'd0;
                        end else if (op_e'(cmd_op) == OP_RUN_IDLE) begin
                            state_q <= ST_RUN;
                            tms_q   <= 1'b0;
                        end else begin
                            state_q <= ST_HEADER;
                            tms_q   <= hdr_tms(op_e'(cmd_op), 6'd0);
                        end
                    end
                end
                ST_HEADER: if (tck_fall) begin
                    if (cnt_q != hdr_last(op_q)) begin
                        cnt_q <= cnt_inc;
                        tms_q <= hdr_tms(op_q, cnt_inc);
                    end else if (op_q == OP_TAP_RESET) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= 6'd0;
                        tms_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= 32'd0;
                    end else begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= 6'd0;
                        tms_q   <= (len_q == 6'd1);
                        tdi_q   <= data_q[0];
                    end
                end
                ST_SHIFT: begin
                    if (tck_rise) cap_q[cnt_q[4:0]] <= tdo;
                    if (tck_fall) begin
                        if (cnt_q == len_m1) begin
                            state_q <= ST_TRAILER;
                            cnt_q   <= 6'd0;
                            tms_q   <= 1'b1;
                            tdi_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                            tms_q <= (cnt_inc == len_m1);
                            tdi_q <= data_q[cnt_inc[4:0]];
                        end
                    end
                end
                ST_TRAILER: if (tck_fall) begin
                    if (cnt_q == 6'd1) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= 6'd0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= cap_q;
                    end else begin
                        cnt_q <= cnt_inc;
                        tms_q <= 1'b0;
                    end
                end
                ST_RUN: if (tck_fall) begin
                    if (cnt_q == len_m1) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= 6'd0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= 32'd0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign trst      = trst_q;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master against a small behavioural TAP (IDCODE 0xBEEFCAFE,
// 8-bit USER register), with a response scoreboard.
module tb_jtag_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        tck, tms, tdi, trst;
    logic        tdo;

    always #5 clk = ~clk;

    jtag_master #(.CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
    );

    // ---------------- TAP model ----------------
    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7,
                   UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;
    localparam logic [5:0] IR_IDCODE = 6'h1E, IR_USER = 6'h01;

    int          tap_st;
    logic [5:0]  ir, ir_sr;
    logic [31:0] dr_sr;
    logic [7:0]  user_reg;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge tck or posedge trst) begin
        if (trst) begin
            tap_st   <= TLR;
            ir       <= IR_IDCODE;
            ir_sr    <= 6'd0;
            dr_sr    <= 32'd0;
            user_reg <= 8'd0;
        end else begin
            case (tap_st)
                TLR:  ir <= IR_IDCODE;
                CDR:  dr_sr <= (ir == IR_IDCODE) ? 32'hBEEFCAFE :
                               (ir == IR_USER)   ? {24'd0, user_reg} : 32'd0;
                SHDR: dr_sr <= (ir == IR_IDCODE) ? {tdi, dr_sr[31:1]} :
                               (ir == IR_USER)   ? {24'd0, tdi, dr_sr[7:1]} : {31'd0, tdi};
                UDR:  if (ir == IR_USER) user_reg <= dr_sr[7:0];
                CIR:  ir_sr <= 6'b000001;
                SHIR: ir_sr <= {tdi, ir_sr[5:1]};
                UIR:  ir <= ir_sr;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck or posedge trst) begin
        if (trst) tdo <= 1'b0;
        else      tdo <= (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;
    end

    // ---------------- TCK observation ----------------
    int          tck_rises = 0, trst_rises = 0;
    time         last_rise = 0, tck_period = 0;
    logic [63:0] tms_log = 64'd0, tdi_log = 64'd0;

    always @(posedge tck) begin
        tck_rises++;
        if (trst) trst_rises++;
        tck_period = $time - last_rise;
        last_rise  = $time;
        tms_log    = {tms_log[62:0], tms};
        tdi_log    = {tdi_log[62:0], tdi};
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [31:0] data; logic err; } exp_t;
    exp_t exp_q[$];
    int   n_checks = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid with data %h, expected no response", rsp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_tck,
                        input int pat_n, input logic [63:0] exp_tms, input logic [63:0] exp_tdi);
        int r0;
        exp_t e;
        logic [63:0] m;
        wait_ready();
        r0 = tck_rises;
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        e.data = exp_d; e.err = exp_e;
        exp_q.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (exp_e) begin
            @(negedge clk);
            check("reject_rsp_next_cycle", {31'd0, rsp_valid}, 32'd1);
        end
        wait_empty();
        repeat (2) @(negedge clk);
        check("rsp_data_hold", rsp_data, exp_d);
        check("tck_count", 32'(tck_rises - r0), 32'(exp_tck));
        if (pat_n > 0) begin
            m = (64'd1 << pat_n) - 64'd1;
            check("tms_pattern", 32'(tms_log & m), 32'(exp_tms));
            check("tdi_pattern", 32'(tdi_log & m), 32'(exp_tdi));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_tck", {31'd0, tck}, 32'd0);
        check("rst_tms", {31'd0, tms}, 32'd1);
        check("rst_tdi", {31'd0, tdi}, 32'd0);
        check("rst_trst", {31'd0, trst}, 32'd1);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
    endtask

    task automatic release_and_check_init();
        int r0, t0;
        @(negedge clk);
        r0 = tck_rises;
        t0 = trst_rises;
        rst_n = 1'b1;
        wait_ready();
        check("init_tck_count", 32'(tck_rises - r0), 32'd6);
        check("init_trst_tcks", 32'(trst_rises - t0), 32'd1);
        check("init_tms_pattern", 32'(tms_log[5:0]), 32'b111110);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, n, premature;
        exp_t e;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        release_and_check_init();
        check("tck_period_ns", 32'(tck_period), 32'd40);

        send(2'd1, 6'd6,  32'h1E, 32'h01, 1'b0, 12, 0, 64'd0, 64'd0);
        send(2'd2, 6'd32, 32'h0,  32'hBEEFCAFE, 1'b0, 37, 0, 64'd0, 64'd0);

        send(2'd1, 6'd6, 32'h01, 32'h01, 1'b0, 12, 0, 64'd0, 64'd0);
        send(2'd2, 6'd8, 32'hA5, 32'h00, 1'b0, 13, 0, 64'd0, 64'd0);
        send(2'd2, 6'd8, 32'h00, 32'hA5, 1'b0, 13, 0, 64'd0, 64'd0);

        send(2'd2, 6'd0,  32'hFFFF_FFFF, 32'h0, 1'b1, 0, 0, 64'd0, 64'd0);
        send(2'd1, 6'd33, 32'h1234_5678, 32'h0, 1'b1, 0, 0, 64'd0, 64'd0);

        // cmd_valid held across a busy SHIFT_DR; second command must wait
        wait_ready();
        cmd_op = 2'd2; cmd_len = 6'd8; cmd_data = 32'h5A; cmd_valid = 1'b1;
        e.data = 32'h00; e.err = 1'b0; exp_q.push_back(e);
        e.data = 32'h5A; exp_q.push_back(e);
        @(posedge clk);
        #1 cmd_data = 32'h00;
        premature = 0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 1000) begin
            if (cmd_ready) premature++;
            @(negedge clk);
            n++;
        end
        check("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        check("bp_ready_while_busy", 32'(premature), 32'd0);
        check("bp_ready_in_rsp_cycle", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("bp_ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_empty();

        send(2'd0, 6'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 6, 6, 64'b111110, 64'b000000);
        send(2'd3, 6'd3, 32'hFFFF_FFFF, 32'h0, 1'b0, 3, 3, 64'b000, 64'b000);

        // reset in the middle of an IDCODE read
        send(2'd1, 6'd6, 32'h1E, 32'h01, 1'b0, 12, 0, 64'd0, 64'd0);
        wait_ready();
        r0 = tck_rises;
        cmd_op = 2'd2; cmd_len = 6'd32; cmd_data = 32'h0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while ((tck_rises - r0) < 10 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("mid_reset_reached_10th_tck", 32'(tck_rises - r0), 32'd10);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (4) @(negedge clk);
        release_and_check_init();
        send(2'd2, 6'd32, 32'h0, 32'hBEEFCAFE, 1'b0, 37, 0, 64'd0, 64'd0);
        send(2'd2, 6'd2, 32'h2, 32'h2, 1'b0, 7, 7, 64'b1000110, 64'b0000100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
